eth_bus_arb: RTL

ETH_BUS_ARB -- requirements
Module: eth_bus_arb

---
 rtl/eth_bus_arb_if.sv | 50 +++++
 rtl/eth_bus_arb.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/eth_bus_arb_if.sv
// Bundles the EthRecv write port, host access port, shared RAM port and overflow status.
// Latency: none, wires only.
// Backpressure: host waits for host_gnt; Eth cannot stall, excess words are dropped and counted.
interface eth_bus_arb_if;
  logic        eth_wr_stb;
  logic        eth_sel_ram;
  logic [15:0] eth_addr;
  logic [31:0] eth_data;

  logic        host_req;
  logic        host_we;
  logic [15:0] host_addr;
  logic [31:0] host_wdata;
  logic        host_gnt;
  logic        host_rvalid;
  logic [31:0] host_rdata;

  logic        mem_cs;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        eth_pending;
  logic        eth_ovf;
  logic [7:0]  eth_drop_cnt;
  logic        ovf_clr;

  // Arbiter side.
  modport slave (
    input  eth_wr_stb, eth_sel_ram, eth_addr, eth_data,
    input  host_req, host_we, host_addr, host_wdata,
    output host_gnt, host_rvalid, host_rdata,
    output mem_cs, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output eth_pending, eth_ovf, eth_drop_cnt,
    input  ovf_clr
  );

  // Requester / RAM side.
  modport master (
    output eth_wr_stb, eth_sel_ram, eth_addr, eth_data,
    output host_req, host_we, host_addr, host_wdata,
    input  host_gnt, host_rvalid, host_rdata,
    input  mem_cs, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  eth_pending, eth_ovf, eth_drop_cnt,
    output ovf_clr
  );
endinterface

// File: rtl/eth_bus_arb.sv
// Generic power-of-two FIFO with a combinational head view.
// Latency: a pushed word is visible at the head the cycle after the push edge.
// Backpressure: push into a full FIFO is ignored unless a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdat,
  output logic [WIDTH-1:0]         rdat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop && (count != '0);
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop_ok);
  assign rdat    = mem_q[rd_ptr];

  // Storage has no reset; occupancy alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr] <= wdat;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// Shares one single-port RAM between buffered EthRecv writes and host reads/writes.
// Latency: grant and RAM strobe in the request cycle; host read data returns one cycle after grant.
// Backpressure: host holds host_req until host_gnt; Eth words beyond the buffer are dropped and counted.
module eth_bus_arb #(
  parameter int FIFO_DEPTH = 4,
  parameter int ETH_URGENT = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  eth_bus_arb_if.slave  bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] dat;
  } eth_wr_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ETH_LAST  = 2'd1,
    HOST_LAST = 2'd2
  } arb_state_t;

  arb_state_t    state;
  arb_state_t    state_nxt;
  logic          rd_wait;
  logic          rd_wait_nxt;

  logic          eth_push;
  logic          eth_full;
  logic          eth_vld;
  logic          eth_urgent;
  logic          host_vld;
  logic          eth_gnt;
  logic          host_win;
  logic          eth_drop;
  eth_wr_t       push_ent;
  eth_wr_t       head_ent;
  logic [CW-1:0] eth_cnt;

  logic [31:0]   rdata_q;
  logic          ovf_q;
  logic [7:0]    drop_cnt_q;

  assign eth_push = bus.eth_wr_stb & bus.eth_sel_ram;
  assign push_ent = '{addr: bus.eth_addr, dat: bus.eth_data};

  sync_fifo #(
    .WIDTH ($bits(eth_wr_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_eth_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (eth_push),
    .pop   (eth_gnt),
    .wdat  (push_ent),
    .rdat  (head_ent),
    .count (eth_cnt),
    .full  (eth_full)
  );

  assign eth_vld    = (eth_cnt != '0);
  assign eth_urgent = (int'(eth_cnt) >= ETH_URGENT);
  // A second host read must wait for the first one's data to come back.
  assign host_vld   = bus.host_req & (bus.host_we | ~rd_wait);
  assign eth_drop   = eth_push & eth_full & ~eth_gnt;

  // Grant decode and RAM strobes from current-cycle state; IDLE behaves as if host won last.
  always_comb begin
    eth_gnt       = 1'b0;
    host_win      = 1'b0;
    state_nxt     = state;
    rd_wait_nxt   = 1'b0;
    bus.host_gnt  = 1'b0;
    bus.mem_cs    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;

    // Grants are held off while reset is asserted so every output reads zero.
    if (rst_n) begin
      if (eth_vld && eth_urgent) begin
        eth_gnt = 1'b1;
      end else if (eth_vld && host_vld) begin
        if (state == ETH_LAST) host_win = 1'b1;
        else                   eth_gnt  = 1'b1;
      end else if (eth_vld) begin
        eth_gnt = 1'b1;
      end else if (host_vld) begin
        host_win = 1'b1;
      end
    end

    if (eth_gnt) begin
      bus.mem_cs    = 1'b1;
      bus.mem_we    = 1'b1;
      bus.mem_addr  = head_ent.addr;
      bus.mem_wdata = head_ent.dat;
      state_nxt     = ETH_LAST;
    end else if (host_win) begin
      bus.host_gnt  = 1'b1;
      bus.mem_cs    = 1'b1;
      bus.mem_we    = bus.host_we;
      bus.mem_addr  = bus.host_addr;
      bus.mem_wdata = bus.host_wdata;
      rd_wait_nxt   = ~bus.host_we;
      state_nxt     = HOST_LAST;
    end
  end

  // Last-winner memory and outstanding-read flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rd_wait <= 1'b0;
    end else begin
      state   <= state_nxt;
      rd_wait <= rd_wait_nxt;
    end
  end

  // Hold the most recent read word so host_rdata stays stable after the valid pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (rd_wait) begin
      rdata_q <= bus.mem_rdata;
    end
  end

  assign bus.host_rvalid = rd_wait;
  assign bus.host_rdata  = rd_wait ? bus.mem_rdata : rdata_q;

  // Sticky overflow flag and saturating drop counter; a clear beats a simultaneous drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else if (bus.ovf_clr) begin
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else if (eth_drop) begin
      ovf_q <= 1'b1;
      if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign bus.eth_pending  = eth_vld;
  assign bus.eth_ovf      = ovf_q;
  assign bus.eth_drop_cnt = drop_cnt_q;
endmodule
